main_memory_arbiter: RTL

Two-port arbiter placed directly upstream of `MAIN_MEMORY`, between it and the two caches. It accepts read requests from `INSTRUCTION_CACHE` and read/write requests from `DATA_CACHE`, and grants exactly one at a time using round-robin priority. It drives main memory's single request port and returns registered data and status to whichever cache owns the grant.

---
 rtl/main_memory_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/main_memory_arbiter.sv
// main_memory_arbiter
//
// Round-robin arbiter sitting between the instruction cache, the data cache
// and the single request port of main memory. One cache transaction is in
// flight at a time: IDLE picks a requester, GRANT_x holds the latched request
// on the memory port until memory reports done, and RESP_x hands registered
// data and a one-cycle done status back to the owning cache.
//
// Ports:
//   clk, rst           system clock, asynchronous active-high reset
//   i_vis_signal/addr  I-cache request (01 read, anything else idle)
//   i_data, i_status   read data and status (00 idle, 01 busy, 10 done) to I-cache
//   d_vis_signal/addr  D-cache request (01 read, 10 write, 11/00 idle)
//   d_written_data, d_data_type, d_length  D-cache write payload, passed through
//   d_data, d_status   read data and status to D-cache
//   mem_*              request port towards main memory (all registered)
//   mem_data, mem_status  main memory response (10 = done)
module main_memory_arbiter #(
  parameter int ADDR_WIDTH       = 20,
  parameter int DATA_LEN         = 32,
  parameter int ENTRY_INDEX_SIZE = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  i_vis_signal,
  input  logic [ADDR_WIDTH-1:0]       i_vis_addr,
  output logic [DATA_LEN-1:0]         i_data,
  output logic [1:0]                  i_status,
  input  logic [1:0]                  d_vis_signal,
  input  logic [ADDR_WIDTH-1:0]       d_vis_addr,
  input  logic [DATA_LEN-1:0]         d_written_data,
  input  logic [2:0]                  d_data_type,
  input  logic [ENTRY_INDEX_SIZE:0]   d_length,
  output logic [DATA_LEN-1:0]         d_data,
  output logic [1:0]                  d_status,
  output logic [1:0]                  mem_vis_signal,
  output logic [ADDR_WIDTH-1:0]       mem_vis_addr,
  output logic [DATA_LEN-1:0]         mem_written_data,
  output logic [2:0]                  mem_data_type,
  output logic [ENTRY_INDEX_SIZE:0]   mem_length,
  input  logic [DATA_LEN-1:0]         mem_data,
  input  logic [1:0]                  mem_status
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_GRANT_I = 3'd1;
  localparam logic [2:0] ST_GRANT_D = 3'd2;
  localparam logic [2:0] ST_RESP_I  = 3'd3;
  localparam logic [2:0] ST_RESP_D  = 3'd4;

  localparam logic [1:0] ST_VIS_IDLE  = 2'b00;
  localparam logic [1:0] ST_VIS_READ  = 2'b01;
  localparam logic [1:0] ST_VIS_WRITE = 2'b10;
  localparam logic [1:0] ST_VIS_BUSY  = 2'b01;
  localparam logic [1:0] ST_VIS_DONE  = 2'b10;

  logic [2:0] state_r;
  logic [2:0] next_state_s;
  // 1'b0: I-cache owned the most recent grant, 1'b1: D-cache did
  logic       last_grant_r;
  logic       i_req_s;
  logic       d_req_s;
  logic       mem_done_s;
  logic [1:0] i_status_nxt_s;
  logic [1:0] d_status_nxt_s;

  assign i_req_s    = (i_vis_signal == ST_VIS_READ);
  assign d_req_s    = (d_vis_signal == ST_VIS_READ) || (d_vis_signal == ST_VIS_WRITE);
  assign mem_done_s = (mem_status == ST_VIS_DONE);

  // Next-state selection with round-robin tie break in IDLE
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_req_s && d_req_s) begin
          next_state_s = last_grant_r ? ST_GRANT_I : ST_GRANT_D;
        end else if (i_req_s) begin
          next_state_s = ST_GRANT_I;
        end else if (d_req_s) begin
          next_state_s = ST_GRANT_D;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_GRANT_I: begin
        if (mem_done_s) begin
          next_state_s = ST_RESP_I;
        end else begin
          next_state_s = ST_GRANT_I;
        end
      end
      ST_GRANT_D: begin
        if (mem_done_s) begin
          next_state_s = ST_RESP_D;
        end else begin
          next_state_s = ST_GRANT_D;
        end
      end
      ST_RESP_I: next_state_s = ST_IDLE;
      ST_RESP_D: next_state_s = ST_IDLE;
      default:   next_state_s = ST_IDLE;
    endcase
  end

  // Status each cache will see after this edge; a waiting requester reads busy
  always_comb begin
    i_status_nxt_s = ST_VIS_IDLE;
    d_status_nxt_s = ST_VIS_IDLE;
    case (next_state_s)
      ST_GRANT_I: i_status_nxt_s = ST_VIS_BUSY;
      ST_RESP_I:  i_status_nxt_s = ST_VIS_DONE;
      default:    i_status_nxt_s = i_req_s ? ST_VIS_BUSY : ST_VIS_IDLE;
    endcase
    case (next_state_s)
      ST_GRANT_D: d_status_nxt_s = ST_VIS_BUSY;
      ST_RESP_D:  d_status_nxt_s = ST_VIS_DONE;
      default:    d_status_nxt_s = d_req_s ? ST_VIS_BUSY : ST_VIS_IDLE;
    endcase
  end

  // State, grant history, latched memory request and registered responses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r          <= ST_IDLE;
      last_grant_r     <= 1'b1;
      mem_vis_signal   <= ST_VIS_IDLE;
      mem_vis_addr     <= {ADDR_WIDTH{1'b0}};
      mem_written_data <= {DATA_LEN{1'b0}};
      mem_data_type    <= 3'b000;
      mem_length       <= {(ENTRY_INDEX_SIZE+1){1'b0}};
      i_data           <= {DATA_LEN{1'b0}};
      d_data           <= {DATA_LEN{1'b0}};
      i_status         <= ST_VIS_IDLE;
      d_status         <= ST_VIS_IDLE;
    end else begin
      state_r  <= next_state_s;
      i_status <= i_status_nxt_s;
      d_status <= d_status_nxt_s;

      // The mem_* registers are the request latch: loaded only on the
      // IDLE->GRANT edge so live cache inputs never reach memory mid-grant.
      if ((state_r == ST_IDLE) && (next_state_s == ST_GRANT_I)) begin
        last_grant_r     <= 1'b0;
        mem_vis_signal   <= ST_VIS_READ;
        mem_vis_addr     <= i_vis_addr;
        mem_written_data <= {DATA_LEN{1'b0}};
        mem_data_type    <= 3'b000;
        mem_length       <= {(ENTRY_INDEX_SIZE+1){1'b0}};
      end else if ((state_r == ST_IDLE) && (next_state_s == ST_GRANT_D)) begin
        last_grant_r     <= 1'b1;
        mem_vis_signal   <= d_vis_signal;
        mem_vis_addr     <= d_vis_addr;
        mem_written_data <= d_written_data;
        mem_data_type    <= d_data_type;
        mem_length       <= d_length;
      end else if ((next_state_s == ST_RESP_I) || (next_state_s == ST_RESP_D)) begin
        mem_vis_signal   <= ST_VIS_IDLE;
      end

      // Write completions also load d_data; the D-cache ignores it
      if ((state_r == ST_GRANT_I) && mem_done_s) begin
        i_data <= mem_data;
      end
      if ((state_r == ST_GRANT_D) && mem_done_s) begin
        d_data <= mem_data;
      end
    end
  end

endmodule
